// File: rtl/minsec_timer_pkg.sv
// Shared constants, count type and binary-to-BCD helper for the min:sec timer
// and the TM1638 display driver.
package minsec_timer_pkg;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic       MODE_UP   = 1'b0;
  localparam logic       MODE_DOWN = 1'b1;

  typedef struct packed {
    logic [6:0] min;
    logic [5:0] sec;
  } mmss_t;

  // Two-digit packed BCD of a value 0..99
  function automatic logic [7:0] bin2bcd(input logic [6:0] bin);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(bin / 7'd10);
    ones = 4'(bin - 7'(tens) * 7'd10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/minsec_timer_if.sv
// Control and display signal bundle between the timer and its host/display path.
interface minsec_timer_if;

  logic       run;
  logic       mode;
  logic       clear;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic [5:0] sec;
  logic [6:0] min;
  logic [7:0] sec_bcd;
  logic [7:0] min_bcd;
  logic       tick;
  logic       wrap;
  logic       done;

  modport master (
    output run, mode, clear, load, load_min, load_sec,
    input  sec, min, sec_bcd, min_bcd, tick, wrap, done
  );

  modport slave (
    input  run, mode, clear, load, load_min, load_sec,
    output sec, min, sec_bcd, min_bcd, tick, wrap, done
  );

endinterface

// File: rtl/minsec_timer_tick_gen.sv
// Prescaler: emits a registered one-cycle tick every TICK_DIV enabled cycles.
module tick_gen #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          tick_r;
  logic          tick_s;

  // Next prescaler phase; a disabled prescaler holds its phase
  always_comb begin
    cnt_s  = cnt_r;
    tick_s = 1'b0;
    if (sync_clr) begin
      cnt_s = '0;
    end else if (en) begin
      if (cnt_r == LAST) begin
        cnt_s  = '0;
        tick_s = 1'b1;
      end else begin
        cnt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_s = cnt_r;
    end
  end

  // Phase and tick registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      tick_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      tick_r <= tick_s;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/minsec_timer.sv
// Min:sec up/down timer with preset load, clear, run/pause and BCD outputs
// feeding the TM1638 counter display.
module minsec_timer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int MIN_MAX  = 59
) (
  input logic           clk,
  input logic           rst,
  minsec_timer_if.slave bus
);

  import minsec_timer_pkg::*;

  localparam logic [6:0] MIN_TOP = 7'(MIN_MAX);

  mmss_t cnt_r;
  mmss_t cnt_s;
  mmss_t load_val_s;
  logic  wrap_r;
  logic  wrap_s;
  logic  done_r;
  logic  done_s;
  logic  tick_s;
  logic  en_s;
  logic  sclr_s;

  // A finished down-count parks the prescaler so no further ticks arrive
  assign en_s   = bus.run & ~done_r;
  assign sclr_s = bus.clear | bus.load;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (en_s),
    .sync_clr (sclr_s),
    .tick     (tick_s)
  );

  // Preset clamp so an out-of-range load never shows an illegal value
  always_comb begin
    load_val_s.sec = (bus.load_sec > SEC_MAX) ? SEC_MAX : bus.load_sec;
    load_val_s.min = (bus.load_min > MIN_TOP) ? MIN_TOP : bus.load_min;
  end

  // Count step and flags; clear beats load beats a pending tick
  always_comb begin
    cnt_s  = cnt_r;
    wrap_s = 1'b0;
    done_s = done_r;
    if (bus.clear) begin
      cnt_s  = '0;
      done_s = 1'b0;
    end else if (bus.load) begin
      cnt_s  = load_val_s;
      done_s = 1'b0;
    end else if (tick_s && (bus.mode == MODE_DOWN)) begin
      if (cnt_r.sec != 6'd0) begin
        cnt_s.sec = cnt_r.sec - 6'd1;
        if ((cnt_r.sec == 6'd1) && (cnt_r.min == 7'd0)) begin
          done_s = 1'b1;
        end else begin
          done_s = done_r;
        end
      end else if (cnt_r.min != 7'd0) begin
        cnt_s.sec = SEC_MAX;
        cnt_s.min = cnt_r.min - 7'd1;
      end else begin
        done_s = 1'b1;
      end
    end else if (tick_s) begin
      done_s = 1'b0;
      if (cnt_r.sec != SEC_MAX) begin
        cnt_s.sec = cnt_r.sec + 6'd1;
      end else if (cnt_r.min != MIN_TOP) begin
        cnt_s.sec = 6'd0;
        cnt_s.min = cnt_r.min + 7'd1;
      end else begin
        cnt_s  = '0;
        wrap_s = 1'b1;
      end
    end else if (bus.mode == MODE_UP) begin
      done_s = 1'b0;
    end else begin
      done_s = done_r;
    end
  end

  // Count and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r  <= '0;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_s;
      wrap_r <= wrap_s;
      done_r <= done_s;
    end
  end

  assign bus.sec     = cnt_r.sec;
  assign bus.min     = cnt_r.min;
  assign bus.sec_bcd = bin2bcd({1'b0, cnt_r.sec});
  assign bus.min_bcd = bin2bcd(cnt_r.min);
  assign bus.tick    = tick_s;
  assign bus.wrap    = wrap_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_minsec_timer.sv
// Directed bench for minsec_timer (TICK_DIV=4, MIN_MAX=2) with an expected-state
// scoreboard popped one entry per observed clock cycle.
module tb_minsec_timer;

  import minsec_timer_pkg::*;

  logic clk = 1'b0;
  logic rst;

  minsec_timer_if bus();

  minsec_timer #(.TICK_DIV(4), .MIN_MAX(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] sec;
    logic [6:0] min;
    logic       tick;
    logic       wrap;
    logic       done;
  } exp_t;

  exp_t  sb_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;
  int    fail_cnt  = 0;
  string cur_tag   = "init";

  task automatic push(input int s, input int m, input int t, input int w, input int d);
    exp_t e;
    e.sec  = 6'(s);
    e.min  = 7'(m);
    e.tick = 1'(t);
    e.wrap = 1'(w);
    e.done = 1'(d);
    sb_q.push_back(e);
  endtask

  task automatic cmp_front(input string tag);
    exp_t        e;
    logic [15:0] obs;
    logic [15:0] want;
    e    = sb_q.pop_front();
    obs  = {bus.min, bus.sec, bus.tick, bus.wrap, bus.done};
    want = {e.min, e.sec, e.tick, e.wrap, e.done};
    total_cnt++;
    assert (obs === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0d:%0d tick=%b wrap=%b done=%b, expected %0d:%0d tick=%b wrap=%b done=%b",
             tag, bus.min, bus.sec, bus.tick, bus.wrap, bus.done,
             e.min, e.sec, e.tick, e.wrap, e.done);
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total_cnt++;
    assert (obs === want) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (sb_q.size() > 0) cmp_front(cur_tag);
  endtask

  // One tick period: three quiet cycles then the tick cycle, value held throughout
  task automatic period(input int s, input int m, input int w, input int d);
    push(s, m, 0, w, 0 | d); cyc();
    push(s, m, 0, 0, d);     cyc();
    push(s, m, 0, 0, d);     cyc();
    push(s, m, 1, 0, d);     cyc();
  endtask

  initial begin
    rst          = 1'b1;
    bus.run      = 1'b0;
    bus.mode     = MODE_UP;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_min = 7'd0;
    bus.load_sec = 6'd0;

    cur_tag = "reset";
    push(0, 0, 0, 0, 0); cyc();
    push(0, 0, 0, 0, 0); cyc();
    check("reset_bcd", {16'd0, bus.sec_bcd, bus.min_bcd}, 32'h0);

    rst     = 1'b0;
    bus.run = 1'b1;
    cur_tag = "first_tick";
    period(0, 0, 0, 0);
    push(1, 0, 0, 0, 0); cyc();
    repeat (5) cyc();

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    push(0, 0, 0, 0, 0);
    cmp_front("rst_async");
    #2 rst = 1'b0;
    cur_tag = "after_rst";
    period(0, 0, 0, 0);
    push(1, 0, 0, 0, 0); cyc();

    // Up-count wrap 02:58 -> 02:59 -> 00:00
    cur_tag      = "up_wrap";
    bus.load     = 1'b1;
    bus.load_min = 7'd2;
    bus.load_sec = 6'd58;
    bus.mode     = MODE_UP;
    push(58, 2, 0, 0, 0); cyc();
    bus.load = 1'b0;
    check("bcd_0258", {16'd0, bus.sec_bcd, bus.min_bcd}, 32'h5802);
    period(58, 2, 0, 0);
    period(59, 2, 0, 0);
    period(0, 0, 1, 0);
    push(1, 0, 0, 0, 0); cyc();

    // Down-count 01:01 to 00:00, then resume upward
    cur_tag      = "down_done";
    bus.load     = 1'b1;
    bus.load_min = 7'd1;
    bus.load_sec = 6'd1;
    bus.mode     = MODE_DOWN;
    push(1, 1, 0, 0, 0); cyc();
    bus.load = 1'b0;
    period(1, 1, 0, 0);
    period(0, 1, 0, 0);
    for (int s = 59; s >= 1; s--) period(s, 0, 0, 0);
    push(0, 0, 0, 0, 1); cyc();
    cur_tag = "done_hold";
    repeat (6) begin
      push(0, 0, 0, 0, 1); cyc();
    end
    cur_tag  = "done_release";
    bus.mode = MODE_UP;
    period(0, 0, 0, 0);
    push(1, 0, 0, 0, 0); cyc();

    // Pause keeps value and prescaler phase
    cur_tag      = "pause";
    bus.load     = 1'b1;
    bus.load_min = 7'd1;
    bus.load_sec = 6'd10;
    push(10, 1, 0, 0, 0); cyc();
    bus.load = 1'b0;
    push(10, 1, 0, 0, 0); cyc();
    push(10, 1, 0, 0, 0); cyc();
    bus.run = 1'b0;
    repeat (7) begin
      push(10, 1, 0, 0, 0); cyc();
    end
    bus.run = 1'b1;
    push(10, 1, 0, 0, 0); cyc();
    push(10, 1, 1, 0, 0); cyc();
    push(11, 1, 0, 0, 0); cyc();

    // Load clamp
    cur_tag      = "clamp";
    bus.run      = 1'b0;
    bus.load     = 1'b1;
    bus.load_min = 7'd5;
    bus.load_sec = 6'd63;
    push(59, 2, 0, 0, 0); cyc();
    bus.load = 1'b0;
    push(59, 2, 0, 0, 0); cyc();
    check("bcd_0259", {16'd0, bus.sec_bcd, bus.min_bcd}, 32'h5902);

    // Clear coincident with tick
    cur_tag      = "clear_vs_tick";
    bus.run      = 1'b1;
    bus.load     = 1'b1;
    bus.load_min = 7'd1;
    bus.load_sec = 6'd10;
    push(10, 1, 0, 0, 0); cyc();
    bus.load = 1'b0;
    period(10, 1, 0, 0);
    bus.clear = 1'b1;
    push(0, 0, 0, 0, 0); cyc();
    bus.clear = 1'b0;
    period(0, 0, 0, 0);

    // Load coincident with tick
    cur_tag      = "load_vs_tick";
    bus.load     = 1'b1;
    bus.load_min = 7'd1;
    bus.load_sec = 6'd30;
    push(30, 1, 0, 0, 0); cyc();
    bus.load = 1'b0;
    period(30, 1, 0, 0);
    push(31, 1, 0, 0, 0); cyc();

    // BCD of 02:47
    cur_tag      = "bcd";
    bus.run      = 1'b0;
    bus.load     = 1'b1;
    bus.load_min = 7'd2;
    bus.load_sec = 6'd47;
    push(47, 2, 0, 0, 0); cyc();
    bus.load = 1'b0;
    check("bcd_sec", {24'd0, bus.sec_bcd}, 32'h47);
    check("bcd_min", {24'd0, bus.min_bcd}, 32'h02);

    check("sb_drained", sb_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
